// File: rtl/pipereg_elastic.sv
// Two-entry elastic pipeline register (main + skid) with halt latching and flush.
// Define PIPEREG_STATS_EN to build saturating stall/bubble counters; otherwise they read 0.
module pipereg_elastic #(
    parameter int WIDTH = 160,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_halt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [1:0]       dbg_state
);

    // Handshake: a beat moves when valid and ready are both 1 on a rising edge;
    // in_ready depends only on registered state and flush, never on in_valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic               main_halt_q, main_halt_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               skid_halt_q, skid_halt_d;
    logic               halt_seen_q, halt_seen_d;
    logic               in_xfer;
    logic               out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            main_halt_q <= 1'b0;
            skid_q      <= '0;
            skid_halt_q <= 1'b0;
            halt_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            main_halt_q <= main_halt_d;
            skid_q      <= skid_d;
            skid_halt_q <= skid_halt_d;
            halt_seen_q <= halt_seen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_xfer) state_d = ST_ONE;
                ST_ONE: begin
                    if (in_xfer && !out_xfer)      state_d = ST_FULL;
                    else if (!in_xfer && out_xfer) state_d = ST_EMPTY;
                end
                ST_FULL:  if (out_xfer) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // A flushed output transfer is ignored, so the datapath only moves when flush is low.
    always_comb begin
        main_d      = main_q;
        main_halt_d = main_halt_q;
        skid_d      = skid_q;
        skid_halt_d = skid_halt_q;
        halt_seen_d = halt_seen_q;
        if (flush) begin
            halt_seen_d = 1'b0;
        end else begin
            if (in_xfer && in_halt) halt_seen_d = 1'b1;
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_d      = in_data;
                        main_halt_d = in_halt;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d      = in_data;
                        main_halt_d = in_halt;
                    end else if (in_xfer) begin
                        skid_d      = in_data;
                        skid_halt_d = in_halt;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        main_d      = skid_q;
                        main_halt_d = skid_halt_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q != ST_FULL) && !halt_seen_q && !flush;
        out_valid = (state_q != ST_EMPTY);
        out_data  = main_q;
        // Stale main contents after draining must not show a halt marker.
        out_halt  = main_halt_q & out_valid;
        dbg_state = state_q;
    end

`ifdef PIPEREG_STATS_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + 1'b1;
        if (!out_valid && !halt_seen_q && (bubble_q != {CNT_W{1'b1}}))
            bubble_d = bubble_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: doc/pipereg_elastic.md
PIPEREG_ELASTIC -- requirements
Module: pipereg_elastic

Interface
REQ-001 SHALL have parameter WIDTH, default 160, payload bits per beat (packed stage fields).
REQ-002 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-003 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous squash of all held beats.
REQ-006 SHALL have port in_valid  input  1  upstream beat present.
REQ-007 SHALL have port in_ready  output  1  stage can accept a beat this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port in_halt  input  1  beat carries halt marker.
REQ-010 SHALL have port out_valid  output  1  downstream beat present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-012 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-013 SHALL have port out_halt  output  1  halt marker of presented beat.
REQ-014 SHALL have port stall_cnt  output  CNT_W  cycles out_valid=1, out_ready=0.
REQ-015 SHALL have port bubble_cnt  output  CNT_W  cycles out_valid=0, not halted.

Function
REQ-016 SHALL implement a 2-entry elastic buffer (main + skid register) with states EMPTY, ONE, FULL.
REQ-017 SHALL define input transfer as in_valid and in_ready both 1, output transfer as out_valid and out_ready both 1.
REQ-018 SHALL drive in_ready = (state != FULL) and not halt_seen and not flush, from registered state only plus flush.
REQ-019 SHALL drive out_valid = 1 in ONE and FULL, out_data/out_halt from main register.
REQ-020 SHALL transition EMPTY -> ONE on input transfer, main <= in.
REQ-021 SHALL in ONE: in+out transfer -> ONE, main <= in; in only -> FULL, skid <= in; out only -> EMPTY.
REQ-022 SHALL in FULL: out transfer -> ONE, main <= skid; otherwise hold.
REQ-023 SHALL give minimum latency 1 cycle from input transfer to out_valid.
REQ-024 SHALL hold out_data and out_halt stable while out_valid=1 and out_ready=0.
REQ-025 SHALL preserve beat order, never drop or duplicate an accepted beat absent flush.
REQ-026 SHALL set halt_seen on input transfer of a beat with in_halt=1, forcing in_ready=0 until reset or flush.
REQ-027 SHALL keep the halt beat deliverable; out_halt=1 only while that beat is in main.
REQ-028 SHALL on flush=1: next state EMPTY, halt_seen cleared, no input accepted that cycle, output transfer that cycle ignored by stage state.
REQ-029 SHALL sustain one beat per cycle throughput when out_ready=1 continuously.

Reset
REQ-030 SHALL on nRST=0 immediately force state EMPTY, halt_seen 0, main/skid data 0, stall_cnt 0, bubble_cnt 0.
REQ-031 SHALL thus present in_ready=1, out_valid=0, out_data=0, out_halt=0 during and after reset, flush=0.
REQ-032 SHALL discard held beats on reset mid-operation; first accepted beat after release appears 1 cycle later.

Configuration
REQ-033 SHALL with macro PIPEREG_STATS_EN defined implement stall_cnt and bubble_cnt as saturating counters (hold at all-ones), cleared by reset only, not flush.
REQ-034 SHALL with PIPEREG_STATS_EN undefined keep both ports, tie them to 0, infer no counter logic.

Verification
REQ-035 SHALL verify streaming: in_valid=1 beats 1..8, out_ready=1 -> out_data 1..8 on consecutive cycles, first 1 cycle after acceptance, in_ready always 1.
REQ-036 SHALL verify backpressure: out_ready=0 while sending A,B,C -> A,B accepted, in_ready=0 from cycle after B; release -> A,B,C delivered in order, out_data held stable.
REQ-037 SHALL verify halt: beat 0x5 with in_halt=1 then beat 0x6 -> 0x6 never accepted, out_halt=1 with 0x5, in_ready stays 0 until flush.
REQ-038 SHALL verify flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, input beat not accepted.
REQ-039 SHALL verify async reset asserted mid-FULL between edges -> out_valid=0 immediately; with PIPEREG_STATS_EN, CNT_W=4, 20 stalled cycles -> stall_cnt=15.
